// File: rtl/ahb_lite_master.sv
// ahb_lite_master
//
// Command-driven AHB-lite initiator for a slave without hready. It buffers read and write
// commands in a small FIFO and issues them as pipelined transfers. Each transfer has an
// address phase followed by exactly one data-phase cycle. Every command produces exactly one
// response strobe, in command order.
//
// Optional feature (macro AHB_RDATA_ALIGN_EN):
//   - Right-justifies and zero-extends read data by size and address.
//   - Replicates byte and halfword write data across all byte lanes.
//
// Ports:
//   clk, n_rst                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         command handshake (cmd_ready = FIFO not full)
//   cmd_write/addr/size/wdata   command payload
//   hsel/haddr/hsize/htrans/hwrite/hwdata  AHB-lite request side
//   hrdata/hresp                AHB-lite data-phase return
//   rsp_valid/rsp_rdata/rsp_error  one-cycle response per command
//   busy                        FIFO non-empty or transfer in flight

module ahb_lite_master #(
    parameter int unsigned CMD_DEPTH = 4
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [3:0]  cmd_addr,
    input  logic [1:0]  cmd_size,
    input  logic [31:0] cmd_wdata,
    output logic        hsel,
    output logic [3:0]  haddr,
    output logic [1:0]  hsize,
    output logic [1:0]  htrans,
    output logic        hwrite,
    output logic [31:0] hwdata,
    input  logic [31:0] hrdata,
    input  logic        hresp,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        busy
);

    localparam int unsigned PtrW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    typedef struct packed {
        logic        write;
        logic [3:0]  addr;
        logic [1:0]  size;
        logic [31:0] wdata;
    } cmd_t;

    cmd_t            mem_q [CMD_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q, count_d;
    logic            full, empty, push, pop;
    cmd_t            head;

    logic            dphase_q;      // data phase in progress this cycle
    logic            dp_write_q;    // direction of the transfer in its data phase
    logic [31:0]     ap_wdata_q;    // write data of the transfer in its address phase
    logic [31:0]     wdata_lanes;
    logic [31:0]     rdata_aligned;
`ifdef AHB_RDATA_ALIGN_EN
    logic [1:0]      dp_addr_q;
    logic [1:0]      dp_size_q;
`endif

    assign full      = (count_q == CntW'(CMD_DEPTH));
    assign empty     = (count_q == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign head      = mem_q[rd_ptr_q];
    // An erroring data phase blocks issue for one edge, giving the single IDLE
    // recovery cycle; the address phase already on the bus is unaffected.
    assign pop       = !empty && !(dphase_q && hresp);

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_comb begin
        wdata_lanes = ap_wdata_q;
`ifdef AHB_RDATA_ALIGN_EN
        case (hsize)
            2'd0:    wdata_lanes = {4{ap_wdata_q[7:0]}};
            2'd1:    wdata_lanes = {2{ap_wdata_q[15:0]}};
            default: wdata_lanes = ap_wdata_q;
        endcase
`endif
    end

    always_comb begin
        rdata_aligned = hrdata;
`ifdef AHB_RDATA_ALIGN_EN
        case (dp_size_q)
            2'd0:    rdata_aligned = {24'h0, hrdata[{dp_addr_q, 3'b000} +: 8]};
            2'd1:    rdata_aligned = {16'h0, hrdata[{dp_addr_q[1], 4'b0000} +: 16]};
            default: rdata_aligned = hrdata;
        endcase
`endif
    end

    // FIFO storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{write: cmd_write, addr: cmd_addr, size: cmd_size,
                                 wdata: cmd_wdata};
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            hsel       <= 1'b0;
            haddr      <= '0;
            hsize      <= '0;
            htrans     <= 2'b00;
            hwrite     <= 1'b0;
            hwdata     <= '0;
            ap_wdata_q <= '0;
            dphase_q   <= 1'b0;
            dp_write_q <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_error  <= 1'b0;
            busy       <= 1'b0;
`ifdef AHB_RDATA_ALIGN_EN
            dp_addr_q  <= '0;
            dp_size_q  <= '0;
`endif
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_d;

            // Address phase
            hsel   <= pop;
            htrans <= pop ? 2'b10 : 2'b00;
            if (pop) begin
                haddr      <= head.addr;
                hsize      <= head.size;
                hwrite     <= head.write;
                ap_wdata_q <= head.wdata;
            end

            // Data phase follows the address phase unconditionally (no hready)
            dphase_q <= hsel;
            if (hsel) begin
                dp_write_q <= hwrite;
`ifdef AHB_RDATA_ALIGN_EN
                dp_addr_q  <= haddr[1:0];
                dp_size_q  <= hsize;
`endif
            end
            if (hsel && hwrite) hwdata <= wdata_lanes;

            // Response for the data phase that just ended
            rsp_valid <= dphase_q;
            if (dphase_q) begin
                rsp_error <= hresp;
                rsp_rdata <= dp_write_q ? 32'h0 : rdata_aligned;
            end

            busy <= (count_d != '0) || pop || hsel;
        end
    end

endmodule
